// File: rtl/rv_mc_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, opcodes
// and the datapath mux/ALU select codes.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus instruction function fields onto
// the ALU operation select.
module rv_alu_decoder
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for R-type; for addi it is immediate data
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control unit of the RV32I multicycle datapath: sequencing FSM, Moore
// output decode, branch resolution, ImmSrc decode and the ALU decoder.
module rv_multicycle_ctrl
  import rv_mc_pkg::*;
#(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] state_o,
  output logic       instr_done
);

  state_e     state_q, state_d;
  logic       pc_update, branch, taken;
  logic       ir_write, reg_write, mem_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        ir_write  = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default: begin
            state_d    = S_FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = SUPPORT_BNE ? ~Zero : 1'b0;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BR:       ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      OP_LUI:      ImmSrc = IMM_U;
      default:     ImmSrc = IMM_I;
    endcase
  end

  // Write enables are gated by reset itself so an aborted instruction can
  // never commit anything while reset is held.
  assign PCWrite  = ~reset & (pc_update | (branch & taken));
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign MemWrite = ~reset & mem_write;
  assign state_o  = state_q;

  rv_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

endmodule
